car2_sprite_fetch: RTL and testbench
====================================

Name: car2_sprite_fetch

Overview:
- Address generator and visibility controller directly upstream of the car-2 sprite ROM (16-bit read address, 4-bit palette index to 24-bit RGB, one-cycle registered read).
- Converts the VGA scan position plus the car's position and lives count into a ROM read address, and selects the damage frame per life count (5 frames × 8320 words).
- Emits a sprite_on flag delay-matched to the ROM's RGB output so the colour mapper can mux it directly.
- Owns a hit-blink state machine that flashes the car for a fixed number of video frames after a collision.

Parameters:
SPR_W, 64, sprite width in pixels
SPR_H, 130, sprite height in pixels (SPR_W*SPR_H = FRAME_WORDS)
FRAME_WORDS, 8320, ROM words per lives frame
MAX_LIVES, 5, lives value mapped to frame 0
BLINK_FRAMES, 60, video frames the blink lasts after a hit
BLINK_HALF, 4, video frames per on/off half-period

Ports:
Clk  in  1  pixel-domain clock
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  vsync-rate level; rising edge marks frame start
DrawX  in  10  current scan column (0..639)
DrawY  in  10  current scan row (0..479)
car_x  in  10  sprite top-left column
car_y  in  10  sprite top-left row
lives  in  3  remaining lives (0..7)
hit  in  1  one-cycle collision pulse
read_address  out  16  to sprite ROM
sprite_on  out  1  aligned with ROM data_out
blinking  out  1  high while the blink state machine is active

Behaviour:
- Reset (synchronous, active-high; Clk rising edge with Reset=1): read_address=0, sprite_on=0, blinking=0, FSM=SHOW, latched position/lives=0, frame edge detector cleared, pipeline valids cleared.
- Frame latch: detect the frame_clk rising edge via a registered copy. On the edge, latch car_x, car_y and min(lives, MAX_LIVES). All address math uses the latched values only, so there is no mid-frame tearing.
- Stage 1 (registered):
  - in_box = DrawX >= x_l && DrawX < x_l+SPR_W && DrawY >= y_l && DrawY < y_l+SPR_H, compared at 11 bits so there is no wrap near 639/479. A sprite partly off-screen clips naturally.
  - col = DrawX-x_l, row = DrawY-y_l.
  - read_address = (MAX_LIVES-lives_l)*FRAME_WORDS + row*SPR_W + col, computed in 16-bit unsigned; the maximum is 41599.
  - Outside the box, read_address holds 0.
- Stage 2: the visibility flag is delayed one more cycle to match the ROM register.
  - sprite_on is asserted 2 Clk cycles after the DrawX/DrawY that produced it.
  - sprite_on = in_box_d2 && visible_d2 && lives_l != 0.
- lives_l = 0: sprite_on is forced to 0 and read_address is forced to 0.
- FSM states:
  - SHOW: visible=1.
    - hit → BLINK_OFF, blink counter = BLINK_FRAMES, phase counter = BLINK_HALF.
  - BLINK_OFF / BLINK_ON: visible = 0 / 1 respectively; blinking=1.
    - Each frame edge decrements both counters.
    - Phase reaching 0 toggles the OFF/ON state and reloads the phase counter.
    - Blink counter reaching 0 → SHOW from either state.
- hit during BLINK_*: restarts the blink counter; the current phase is kept.
- hit coinciding with a frame edge: the restart wins; decrements are skipped that cycle.
- Visibility changes only take effect at frame edges, except the hit transition, which is immediate.
- Reset mid-blink returns to SHOW immediately.

Optional Feature:
- Macro: CAR2_MIRROR_EN.
- Defined: adds input port mirror (1 bit), latched at frame start. When mirror_l=1, the column term becomes SPR_W-1-col, flipping the car horizontally. Timing is unchanged.
- Undefined: the port is absent and col is used directly.

Decomposition:
- Package car2_sprite_pkg:
  - Constants SPR_W, SPR_H, FRAME_WORDS, MAX_LIVES.
  - Enum blink_state_t {SHOW, BLINK_ON, BLINK_OFF}.
  - Function frame_base(lives) returning 16-bit base address, implemented as a case on 1..5.
- One sub-module, car2_blink_fsm: inputs Clk, Reset, frame_edge, hit; outputs visible, blinking.

Test Plan:
- Reset, then lives=5, car=(100,200), frame edge, DrawX=100/DrawY=200 → read_address=0; sprite_on=1 two cycles later.
- lives=3, car=(100,200), DrawX=163/DrawY=329 → read_address=16640+129*64+63=24959; DrawX=164 → sprite_on=0.
- car_x changed mid-frame from 100 to 300 → addresses keep using 100 until the next frame_clk rising edge.
- lives=0 → sprite_on=0 and read_address=0 across the whole frame; lives=7 → treated as 5 (base 0).
- hit pulse → blinking=1, sprite_on 0 for 4 frames then 1 for 4 frames, alternating; blinking=0 and SHOW after 60 frames.
- Second hit at frame 30 of a blink → blink ends 60 frames after the second hit; Reset asserted mid-blink → blinking=0 on the next cycle.

Source files
------------

// File: rtl/car2_sprite_pkg.sv
// Shared constants, blink state encoding and lives-to-frame mapping for the car-2 sprite.
// Optional horizontal mirroring is enabled in the top with CAR2_MIRROR_EN.
package car2_sprite_pkg;

    localparam int unsigned SPR_W        = 64;
    localparam int unsigned SPR_H        = 130;
    localparam int unsigned FRAME_WORDS  = 8320;
    localparam int unsigned MAX_LIVES    = 5;
    localparam int unsigned BLINK_FRAMES = 60;
    localparam int unsigned BLINK_HALF   = 4;

    typedef enum logic [1:0] {
        SHOW,
        BLINK_ON,
        BLINK_OFF
    } blink_state_t;

    // Full health shows frame 0; each lost life steps one frame further into the ROM.
    function automatic logic [15:0] frame_base(input logic [2:0] lives);
        logic [15:0] base;
        case (lives)
            3'd5:    base = 16'd0;
            3'd4:    base = 16'd8320;
            3'd3:    base = 16'd16640;
            3'd2:    base = 16'd24960;
            3'd1:    base = 16'd33280;
            default: base = 16'd0;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/car2_blink_fsm.sv
// Post-collision blink controller: toggles visibility every BLINK_HALF frames
// for BLINK_FRAMES frames after a hit, restarting on any further hit.
module car2_blink_fsm
    import car2_sprite_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic frame_edge,
    input  logic hit,
    output logic visible,
    output logic blinking
);

    localparam logic [5:0] BLINK_CNT = 6'(BLINK_FRAMES);
    localparam logic [2:0] HALF_CNT  = 3'(BLINK_HALF);

    blink_state_t state_q, state_d;
    logic [5:0] blink_q, blink_d;
    logic [2:0] phase_q, phase_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= SHOW;
            blink_q <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blink_d = blink_q;
        phase_d = phase_q;
        unique case (state_q)
            SHOW: begin
                if (hit) begin
                    state_d = BLINK_OFF;
                    blink_d = BLINK_CNT;
                    phase_d = HALF_CNT;
                end
            end
            BLINK_ON, BLINK_OFF: begin
                // A hit on a frame edge restarts and skips that edge's decrement.
                if (hit) begin
                    blink_d = BLINK_CNT;
                end else if (frame_edge) begin
                    blink_d = blink_q - 6'd1;
                    phase_d = phase_q - 3'd1;
                    if (blink_q == 6'd1) begin
                        state_d = SHOW;
                    end else if (phase_q == 3'd1) begin
                        state_d = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                        phase_d = HALF_CNT;
                    end
                end
            end
            default: state_d = SHOW;
        endcase
    end

    assign visible  = (state_q != BLINK_OFF);
    assign blinking = (state_q != SHOW);

endmodule

// File: rtl/car2_sprite_fetch.sv
// Car-2 sprite ROM address generator with frame-latched position and damage frame.
// Define CAR2_MIRROR_EN to add the mirror input for horizontal flipping.
module car2_sprite_fetch
    import car2_sprite_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  car_x,
    input  logic [9:0]  car_y,
    input  logic [2:0]  lives,
    input  logic        hit,
`ifdef CAR2_MIRROR_EN
    input  logic        mirror,
`endif
    output logic [15:0] read_address,
    output logic        sprite_on,
    output logic        blinking
);

    logic       frame_q;
    logic       frame_edge;
    logic [9:0] x_l;
    logic [9:0] y_l;
    logic [2:0] lives_l;
    logic       visible;
    logic       live;
    logic       in_box;
    logic [5:0] col;
    logic [5:0] col_eff;
    logic [7:0] row;
    logic [15:0] addr;
    logic       in_box_d1;
    logic       vis_d1;

    assign frame_edge = frame_clk & ~frame_q;

`ifdef CAR2_MIRROR_EN
    logic mirror_l;
`endif

    // Position and lives only change at frame start so a frame never tears.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_q <= 1'b0;
            x_l     <= '0;
            y_l     <= '0;
            lives_l <= '0;
`ifdef CAR2_MIRROR_EN
            mirror_l <= 1'b0;
`endif
        end else begin
            frame_q <= frame_clk;
            if (frame_edge) begin
                x_l     <= car_x;
                y_l     <= car_y;
                lives_l <= (lives > 3'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives;
`ifdef CAR2_MIRROR_EN
                mirror_l <= mirror;
`endif
            end
        end
    end

    car2_blink_fsm u_blink (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_edge (frame_edge),
        .hit        (hit),
        .visible    (visible),
        .blinking   (blinking)
    );

    // 11-bit compares keep the box edge from wrapping near the screen limits.
    assign in_box = ({1'b0, DrawX} >= {1'b0, x_l})
                 && ({1'b0, DrawX} <  ({1'b0, x_l} + 11'(SPR_W)))
                 && ({1'b0, DrawY} >= {1'b0, y_l})
                 && ({1'b0, DrawY} <  ({1'b0, y_l} + 11'(SPR_H)));

    assign live = (lives_l != 3'd0);
    assign col  = DrawX[5:0] - x_l[5:0];
    assign row  = DrawY[7:0] - y_l[7:0];

`ifdef CAR2_MIRROR_EN
    assign col_eff = mirror_l ? (6'(SPR_W - 1) - col) : col;
`else
    assign col_eff = col;
`endif

    // SPR_W is 64, so row*SPR_W+col is a plain bit concatenation.
    assign addr = frame_base(lives_l) + {2'b00, row, col_eff};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            read_address <= '0;
            in_box_d1    <= 1'b0;
            vis_d1       <= 1'b0;
            sprite_on    <= 1'b0;
        end else begin
            read_address <= (in_box && live) ? addr : 16'd0;
            in_box_d1    <= in_box && live;
            vis_d1       <= visible;
            sprite_on    <= in_box_d1 && vis_d1 && live;
        end
    end

endmodule

// File: tb/tb_car2_sprite_fetch.sv
// Directed bench for car2_sprite_fetch: addressing, frame latching, lives and blink.
module tb_car2_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  car_x;
    logic [9:0]  car_y;
    logic [2:0]  lives;
    logic        hit;
    logic [15:0] read_address;
    logic        sprite_on;
    logic        blinking;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    car2_sprite_fetch dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .car_x        (car_x),
        .car_y        (car_y),
        .lives        (lives),
        .hit          (hit),
`ifdef CAR2_MIRROR_EN
        .mirror       (1'b0),
`endif
        .read_address (read_address),
        .sprite_on    (sprite_on),
        .blinking     (blinking)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        tick();
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y,
                         input int exp_addr, input int exp_on);
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
        chk({tag, "_addr"}, int'(read_address), exp_addr);
        tick();
        chk({tag, "_on"}, int'(sprite_on), exp_on);
    endtask

    initial begin
        Reset = 1'b1;
        frame_clk = 1'b0;
        DrawX = '0;
        DrawY = '0;
        car_x = '0;
        car_y = '0;
        lives = '0;
        hit = 1'b0;
        tick();
        tick();
        chk("rst_addr", int'(read_address), 0);
        chk("rst_on", int'(sprite_on), 0);
        chk("rst_blink", int'(blinking), 0);
        Reset = 1'b0;

        lives = 3'd5; car_x = 10'd100; car_y = 10'd200;
        frame();
        probe("l5_tl", 100, 200, 0, 1);
        probe("l5_br", 163, 329, 8319, 1);
        probe("l5_r1", 101, 201, 65, 1);

        lives = 3'd3;
        frame();
        probe("l3_br", 163, 329, 24959, 1);
        probe("l3_right", 164, 329, 0, 0);
        probe("l3_below", 100, 330, 0, 0);
        probe("l3_left", 99, 200, 0, 0);

        car_x = 10'd300;
        probe("mid_old", 100, 200, 16640, 1);
        probe("mid_new", 300, 200, 0, 0);
        frame();
        probe("nxt_old", 100, 200, 0, 0);
        probe("nxt_new", 300, 200, 16640, 1);

        lives = 3'd0;
        frame();
        probe("l0_a", 300, 200, 0, 0);
        probe("l0_b", 340, 280, 0, 0);
        lives = 3'd7;
        frame();
        probe("l7_a", 300, 200, 0, 1);
        probe("l7_b", 301, 201, 65, 1);

        car_x = 10'd600; car_y = 10'd460; lives = 3'd5;
        frame();
        probe("clip", 639, 479, 1255, 1);
        probe("clip_out", 5, 470, 0, 0);

        car_x = 10'd100; car_y = 10'd200;
        frame();
        pulse_hit();
        chk("hit_blink", int'(blinking), 1);
        probe("hit_off", 100, 200, 0, 0);
        for (int k = 1; k <= 60; k++) begin
            frame();
            probe($sformatf("blk%0d", k), 100, 200, 0,
                  (k >= 60) ? 1 : ((k / 4) % 2));
            chk($sformatf("blk%0d_flag", k), int'(blinking), (k < 60) ? 1 : 0);
        end

        pulse_hit();
        for (int k = 1; k <= 30; k++) frame();
        pulse_hit();
        for (int k = 1; k <= 59; k++) frame();
        chk("rehit_59", int'(blinking), 1);
        frame();
        chk("rehit_60", int'(blinking), 0);

        pulse_hit();
        for (int k = 1; k <= 5; k++) frame();
        chk("pre_rst", int'(blinking), 1);
        Reset = 1'b1;
        tick();
        chk("mid_rst_blink", int'(blinking), 0);
        chk("mid_rst_on", int'(sprite_on), 0);
        Reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
